// File: rtl/jk_pkg.sv
// Shared definitions for the JK flip-flop bank driver.
// Holds the request mode encodings and the driver FSM state encoding.
package jk_pkg;

  typedef enum logic [1:0] {
    MODE_LOAD   = 2'b00,
    MODE_HOLD   = 2'b01,
    MODE_TOGGLE = 2'b10,
    MODE_CLEAR  = 2'b11
  } mode_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DRIVE = 3'd1,
    CHECK = 3'd2,
    DONE  = 3'd3,
    FAIL  = 3'd4
  } state_e;

endpackage

// File: rtl/jk_excite.sv
// Minimal JK excitation for a bank of WIDTH JK flip-flops.
// Purely combinational.
// Ports:
//   mode   - requested operation (jk_pkg::mode_e encoding)
//   target - desired Q for load; ignored for other modes
//   q      - current bank Q
//   j, k   - per-bit J/K drive
//   rst    - clear request for the bank's reset pin
module jk_excite
  import jk_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] target,
  input  logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             rst
);

  always_comb begin
    // NOTE: every output gets a default before the case, so no path leaves
    // a signal unassigned and no latch is inferred.
    j   = '0;
    k   = '0;
    rst = 1'b0;
    case (mode)
      MODE_LOAD: begin
        // Only bits that differ get driven; equal bits stay at J=K=0.
        j = target & ~q;
        k = ~target & q;
      end
      MODE_TOGGLE: begin
        j = '1;
        k = '1;
      end
      MODE_CLEAR: rst = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/jk_bank_driver.sv
// Initiator for an external bank of WIDTH JK flip-flops sharing Clk.
// Turns a load/hold/toggle/clear request into one cycle of JK excitation,
// checks the bank readback one cycle later, and re-drives load/clear up to
// MAX_RETRY times on mismatch.
// Ports:
//   Clk, R            - clock, synchronous active-high reset
//   req_valid/ready   - request handshake; req_mode, req_data sampled on accept
//   jk_j, jk_k, jk_rst- registered drive into the bank
//   q_in              - bank Q readback
//   done, err, result - completion pulse, failure flag, Q at the final check
//   err_count         - saturating FAIL count (only with JK_ERR_COUNT_EN)
// Optional feature macro: JK_ERR_COUNT_EN.
module jk_bank_driver
  import jk_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MAX_RETRY = 2
) (
  input  logic             Clk,
  input  logic             R,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_mode,
  input  logic [WIDTH-1:0] req_data,
  output logic [WIDTH-1:0] jk_j,
  output logic [WIDTH-1:0] jk_k,
  output logic             jk_rst,
  input  logic [WIDTH-1:0] q_in,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] result
`ifdef JK_ERR_COUNT_EN
  ,
  output logic [7:0]       err_count
`endif
);

  localparam logic [2:0] MAX_RETRY_C = 3'(MAX_RETRY);

  state_e           state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [WIDTH-1:0] expected_q, expected_d;
  logic [2:0]       retry_q, retry_d;
  logic [WIDTH-1:0] j_q, j_d, k_q, k_d;
  logic             rst_q, rst_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d, err_q, err_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic             idle_like;
  logic [1:0]       ex_mode;
  logic [WIDTH-1:0] ex_target, ex_j, ex_k;
  logic             ex_rst;

  // DONE/FAIL accept like IDLE, so a new request can start on the edge
  // that ends the completion cycle.
  assign idle_like = (state_q == IDLE) || (state_q == DONE) || (state_q == FAIL);

  // One excitation unit serves both the initial drive (fresh request) and
  // retries (captured mode against the captured expected value).
  assign ex_mode   = idle_like ? req_mode : mode_q;
  assign ex_target = idle_like ? req_data : expected_q;

  jk_excite #(.WIDTH(WIDTH)) u_excite (
    .mode   (ex_mode),
    .target (ex_target),
    .q      (q_in),
    .j      (ex_j),
    .k      (ex_k),
    .rst    (ex_rst)
  );

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    expected_d = expected_q;
    retry_d    = retry_q;
    j_d        = '0;
    k_d        = '0;
    rst_d      = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    result_d   = result_q;
    case (state_q)
      IDLE, DONE, FAIL: begin
        state_d = IDLE;
        retry_d = '0;
        if (req_valid && ready_q) begin
          state_d = DRIVE;
          mode_d  = req_mode;
          case (req_mode)
            MODE_LOAD:   expected_d = req_data;
            MODE_HOLD:   expected_d = q_in;
            MODE_TOGGLE: expected_d = ~q_in;
            default:     expected_d = '0;
          endcase
          j_d   = ex_j;
          k_d   = ex_k;
          rst_d = ex_rst;
        end
      end
      DRIVE: state_d = CHECK;
      CHECK: begin
        if (q_in == expected_q) begin
          state_d  = DONE;
          done_d   = 1'b1;
          result_d = q_in;
        end else if ((retry_q != MAX_RETRY_C) &&
                     ((mode_q == MODE_LOAD) || (mode_q == MODE_CLEAR))) begin
          state_d = DRIVE;
          retry_d = retry_q + 3'd1;
          j_d     = ex_j;
          k_d     = ex_k;
          rst_d   = ex_rst;
        end else begin
          state_d  = FAIL;
          done_d   = 1'b1;
          err_d    = 1'b1;
          result_d = q_in;
        end
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE) || (state_d == DONE) || (state_d == FAIL);
  end

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples the pre-edge values computed in always_comb.
  always_ff @(posedge Clk) begin
    if (R) begin
      state_q    <= IDLE;
      mode_q     <= MODE_LOAD;
      expected_q <= '0;
      retry_q    <= '0;
      j_q        <= '0;
      k_q        <= '0;
      rst_q      <= 1'b0;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      expected_q <= expected_d;
      retry_q    <= retry_d;
      j_q        <= j_d;
      k_q        <= k_d;
      rst_q      <= rst_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
      err_q      <= err_d;
      result_q   <= result_d;
    end
  end

  assign req_ready = ready_q;
  assign jk_j      = j_q;
  assign jk_k      = k_q;
  assign jk_rst    = rst_q;
  assign done      = done_q;
  assign err       = err_q;
  assign result    = result_q;

`ifdef JK_ERR_COUNT_EN
  logic [7:0] err_count_q, err_count_d;

  always_comb begin
    err_count_d = err_count_q;
    if ((state_d == FAIL) && (state_q == CHECK) && (err_count_q != 8'hFF))
      err_count_d = err_count_q + 8'd1;
  end

  always_ff @(posedge Clk) begin
    if (R) err_count_q <= '0;
    else   err_count_q <= err_count_d;
  end

  assign err_count = err_count_q;
`endif

endmodule
